serpent_key_ctrl: RTL and testbench
===================================

SERPENT_KEY_CTRL -- requirements
Module: serpent_key_ctrl

Interface
REQ-001 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-002 i_rstn  input  1  asynchronous active-low reset.
REQ-003 i_load_start  input  1  single-cycle pulse: begin loading 33 round keys.
REQ-004 i_sk_valid / o_sk_ready  input / output  1 / 1  subkey stream handshake from key expansion.
REQ-005 i_sk_data  input  128  subkey word; words arrive in round order 0..32.
REQ-006 o_keys_ready  output  1  high when all 33 subkeys are stored and readable.
REQ-007 i_req0, i_req1  input  1 each  read request: 0 = data core, 1 = tweak core.
REQ-008 i_addr0, i_addr1  input  6 each  requested subkey index.
REQ-009 o_gnt0, o_gnt1  output  1 each  combinational grant; request consumed in the grant cycle.
REQ-010 o_vld0, o_vld1  output  1 each  registered read-data valid, one-cycle pulse.
REQ-011 o_key  output  128  registered read data; shared by both requesters, qualified by o_vld0/o_vld1.
REQ-012 o_addr_err  output  1  registered pulse: granted address exceeded 32.
REQ-013 o_mem_write_en, o_mem_read_en  output  1 each  key memory strobes.
REQ-014 o_mem_addr  output  6  key memory address.
REQ-015 o_mem_key / i_mem_key  output / input  128 / 128  key memory write data / combinational read data.

Function
REQ-016 FSM states: IDLE, LOAD, READY.
REQ-017 IDLE->LOAD on i_load_start; load counter cleared to 0; o_keys_ready=0.
REQ-018 In LOAD, o_sk_ready=1; each cycle with i_sk_valid=1 drives o_mem_write_en=1, o_mem_addr=counter, o_mem_key=i_sk_data (combinational), then increments counter.
REQ-019 The write accepting counter value 32 moves LOAD->READY; o_keys_ready goes to 1 in the next cycle.
REQ-020 o_sk_ready=0 outside LOAD; i_sk_valid outside LOAD is ignored.
REQ-021 i_load_start during LOAD is ignored; counter is not cleared.
REQ-022 i_load_start in READY: -> LOAD, counter=0, o_keys_ready=0 next cycle; no grant issued in that cycle.
REQ-023 Grants are issued only in READY; o_gnt0/o_gnt1 = 0 in IDLE and LOAD regardless of requests.
REQ-024 At most one grant per cycle; single requester granted immediately.
REQ-025 Both requesting: grant goes to the requester not granted most recently (round robin); priority register updates on every grant.
REQ-026 Grant cycle with index <= 32: o_mem_read_en=1, o_mem_addr=granted address; i_mem_key captured into o_key; matching o_vldN=1 next cycle.
REQ-027 Grant cycle with index 33..63: o_mem_read_en=0; next cycle o_key=0, matching o_vldN=1, o_addr_err=1.
REQ-028 Read latency: grant in cycle N, data valid in cycle N+1; back-to-back grants sustain one read per cycle.
REQ-029 o_vldN and o_addr_err are 0 in any cycle not following a grant; o_key holds last value otherwise.
REQ-030 o_mem_write_en and o_mem_read_en never both 1 in the same cycle.

Reset
REQ-031 i_rstn low forces immediately: state IDLE, counter 0, round-robin priority to requester 0, all outputs 0 (o_key=0).
REQ-032 Reset mid-LOAD discards progress; after release o_keys_ready stays 0 until a full 33-word load completes.
REQ-033 No key memory strobe asserted while i_rstn is low.

Verification
REQ-034 Reset release, i_load_start, 33 words 0x...00..0x...20 with continuous valid -> 33 writes addr 0..32, o_keys_ready=1 one cycle after last write.
REQ-035 Load with i_sk_valid toggling every other cycle -> writes only on valid cycles, addresses contiguous, completion after 33 accepted words.
REQ-036 READY, i_req0=i_req1=1 for 4 cycles, addr0=5, addr1=7 -> grants 0,1,0,1; o_key = word5, word7, word5, word7 with matching o_vld one cycle later.
REQ-037 READY, i_req1=1, i_addr1=40 -> o_gnt1=1, no mem read, next cycle o_vld1=1, o_key=0, o_addr_err=1.
REQ-038 Requests during LOAD -> no grants; i_load_start in READY -> o_keys_ready falls, reload completes, grants resume.
REQ-039 Assert i_rstn=0 after 10 load words -> outputs 0 asynchronously; new full load required before any grant.

Source files
------------

// File: rtl/serpent_key_ctrl.sv
// Round-key store controller: loads 33 Serpent subkeys into an external key
// memory, then serves round-robin arbitrated reads to the data and tweak cores.
module serpent_key_ctrl (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_load_start,
    input  logic         i_sk_valid,
    output logic         o_sk_ready,
    input  logic [127:0] i_sk_data,
    output logic         o_keys_ready,
    input  logic         i_req0,
    input  logic         i_req1,
    input  logic [5:0]   i_addr0,
    input  logic [5:0]   i_addr1,
    output logic         o_gnt0,
    output logic         o_gnt1,
    output logic         o_vld0,
    output logic         o_vld1,
    output logic [127:0] o_key,
    output logic         o_addr_err,
    output logic         o_mem_write_en,
    output logic         o_mem_read_en,
    output logic [5:0]   o_mem_addr,
    output logic [127:0] o_mem_key,
    input  logic [127:0] i_mem_key
);

    localparam logic [5:0] LAST_IDX = 6'd32;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t         state_reg, state_next;
    logic [5:0]     cnt_reg, cnt_next;
    logic           prio_reg, prio_next;
    logic           keys_ready_reg;
    logic           vld0_reg, vld1_reg, err_reg;
    logic [127:0]   key_reg;
    logic [5:0]     gnt_addr;
    logic           gnt_bad;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        prio_next      = prio_reg;
        o_sk_ready     = 1'b0;
        o_gnt0         = 1'b0;
        o_gnt1         = 1'b0;
        o_mem_write_en = 1'b0;
        o_mem_read_en  = 1'b0;
        o_mem_addr     = 6'd0;
        o_mem_key      = 128'd0;
        gnt_addr       = 6'd0;
        gnt_bad        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_load_start) begin
                    state_next = LOAD;
                    cnt_next   = 6'd0;
                end
            end
            LOAD: begin
                o_sk_ready = 1'b1;
                if (i_sk_valid) begin
                    o_mem_write_en = 1'b1;
                    o_mem_addr     = cnt_reg;
                    o_mem_key      = i_sk_data;
                    cnt_next       = cnt_reg + 6'd1;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                if (i_load_start) begin
                    state_next = LOAD;
                    cnt_next   = 6'd0;
                end else begin
                    // prio_reg=0 favours requester 0 when both ask
                    if (i_req0 && (!i_req1 || !prio_reg)) begin
                        o_gnt0    = 1'b1;
                        gnt_addr  = i_addr0;
                        prio_next = 1'b1;
                    end else if (i_req1) begin
                        o_gnt1    = 1'b1;
                        gnt_addr  = i_addr1;
                        prio_next = 1'b0;
                    end
                    gnt_bad = gnt_addr > LAST_IDX;
                    if ((o_gnt0 || o_gnt1) && !gnt_bad) begin
                        o_mem_read_en = 1'b1;
                        o_mem_addr    = gnt_addr;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg      <= IDLE;
            cnt_reg        <= 6'd0;
            prio_reg       <= 1'b0;
            keys_ready_reg <= 1'b0;
            vld0_reg       <= 1'b0;
            vld1_reg       <= 1'b0;
            err_reg        <= 1'b0;
            key_reg        <= 128'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            prio_reg       <= prio_next;
            keys_ready_reg <= (state_next == READY);
            vld0_reg       <= o_gnt0;
            vld1_reg       <= o_gnt1;
            err_reg        <= (o_gnt0 || o_gnt1) && gnt_bad;
            if (o_gnt0 || o_gnt1) begin
                key_reg <= gnt_bad ? 128'd0 : i_mem_key;
            end
        end
    end

    assign o_keys_ready = keys_ready_reg;
    assign o_vld0       = vld0_reg;
    assign o_vld1       = vld1_reg;
    assign o_addr_err   = err_reg;
    assign o_key        = key_reg;

endmodule

// File: tb/tb_serpent_key_ctrl.sv
// Scoreboard bench for serpent_key_ctrl: directed loads and reads, expected
// writes/reads queued by the stimulus and checked by a negedge monitor.
module tb_serpent_key_ctrl;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         load_start = 1'b0;
    logic         sk_valid = 1'b0;
    logic         sk_ready;
    logic [127:0] sk_data = '0;
    logic         keys_ready;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [5:0]   addr0 = '0, addr1 = '0;
    logic         gnt0, gnt1, vld0, vld1, addr_err;
    logic [127:0] key;
    logic         mem_write_en, mem_read_en;
    logic [5:0]   mem_addr;
    logic [127:0] mem_key, mem_rdata;

    logic [127:0] mem   [0:63];
    logic [127:0] words [0:32];

    int total = 0;
    int bad   = 0;

    typedef struct {logic [5:0] addr; logic [127:0] data;} wr_t;
    typedef struct {logic who; logic [127:0] key; logic err;} rd_t;
    wr_t wq[$];
    rd_t rq[$];
    wr_t mon_w;
    rd_t mon_r;

    always #5 clk = ~clk;

    serpent_key_ctrl dut (
        .i_clk(clk), .i_rstn(rstn), .i_load_start(load_start),
        .i_sk_valid(sk_valid), .o_sk_ready(sk_ready), .i_sk_data(sk_data),
        .o_keys_ready(keys_ready), .i_req0(req0), .i_req1(req1),
        .i_addr0(addr0), .i_addr1(addr1), .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_vld0(vld0), .o_vld1(vld1), .o_key(key), .o_addr_err(addr_err),
        .o_mem_write_en(mem_write_en), .o_mem_read_en(mem_read_en),
        .o_mem_addr(mem_addr), .o_mem_key(mem_key), .i_mem_key(mem_rdata)
    );

    always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_key;
    assign mem_rdata = mem_read_en ? mem[mem_addr] : {4{32'hDEADBEEF}};

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mkw(int seed, int k);
        return {8'(seed), 16'hC0DE, 96'h0, 8'(k)};
    endfunction

    always @(negedge clk) begin
        if (mem_write_en && mem_read_en) chk("strobe_excl", 1, 0);
        if (mem_write_en) begin
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                mon_w = wq.pop_front();
                chk("wr_addr", mem_addr, mon_w.addr);
                chk("wr_data", mem_key, mon_w.data);
                $display("write addr=%0d data=%h", mem_addr, mem_key);
            end
        end
        if (vld0 || vld1) begin
            if (rq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                mon_r = rq.pop_front();
                chk("rd_both_vld", vld0 & vld1, 0);
                chk("rd_who", vld1, mon_r.who);
                chk("rd_key", key, mon_r.key);
                chk("rd_err", addr_err, mon_r.err);
                $display("read who=%0d key=%h err=%0d", vld1, key, addr_err);
            end
        end else if (addr_err) begin
            chk("err_without_vld", 1, 0);
        end
    end

    task automatic do_load(int seed, bit toggle, bit req_during);
        @(posedge clk); #1;
        load_start = 1'b1;
        if (req_during) begin
            req0 = 1'b1; addr0 = 6'd1;
            #1 chk("gnt_on_reload", gnt0, 0);
        end
        @(posedge clk); #1;
        load_start = 1'b0;
        if (req_during) begin
            req0 = 1'b1; req1 = 1'b1; addr1 = 6'd2;
        end
        for (int k = 0; k < 33; k++) begin
            if (toggle) begin
                sk_valid = 1'b0;
                sk_data  = '1;
                if (k == 5) load_start = 1'b1;
                #1;
                if (req_during) begin
                    chk("gnt0_in_load", gnt0, 0);
                    chk("gnt1_in_load", gnt1, 0);
                end
                @(posedge clk); #1;
                load_start = 1'b0;
            end
            sk_valid = 1'b1;
            sk_data  = mkw(seed, k);
            words[k] = sk_data;
            wq.push_back('{6'(k), sk_data});
            #1;
            chk("sk_ready", sk_ready, 1);
            if (k == 32) chk("keys_ready_before_last", keys_ready, 0);
            if (req_during) begin
                chk("gnt0_in_load", gnt0, 0);
                chk("gnt1_in_load", gnt1, 0);
            end
            @(posedge clk); #1;
        end
        sk_valid = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        chk("keys_ready_after_load", keys_ready, 1);
        chk("sk_ready_after_load", sk_ready, 0);
    endtask

    // exp_g: -1 no grant, 0 or 1 the requester expected to win
    task automatic rd(bit r0, logic [5:0] a0, bit r1, logic [5:0] a1, int exp_g);
        logic [5:0]   a;
        logic         e;
        logic [127:0] kexp;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
        #1;
        chk("gnt0", gnt0, exp_g == 0);
        chk("gnt1", gnt1, exp_g == 1);
        if (exp_g >= 0) begin
            a    = (exp_g == 1) ? a1 : a0;
            e    = a > 6'd32;
            kexp = e ? 128'd0 : words[a];
            chk("mem_read_en", mem_read_en, !e);
            rq.push_back('{exp_g == 1, kexp, e});
        end else begin
            chk("mem_read_en_idle", mem_read_en, 0);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_vld0", vld0, 0);
        chk("rst_vld1", vld1, 0);
        chk("rst_key", key, 0);
        chk("rst_err", addr_err, 0);
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_sk_ready", sk_ready, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_strobes", {mem_write_en, mem_read_en}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_key", mem_key, 0);
    endtask

    initial begin
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs();
        @(posedge clk); #1 rstn = 1'b1;

        do_load(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(1, 6'd5, 1, 6'd7, i % 2);
        rd(0, 6'd0, 1, 6'd40, 1);
        rd(1, 6'd32, 0, 6'd0, 0);
        rd(1, 6'd33, 0, 6'd0, 0);
        rd(1, 6'd63, 1, 6'd0, 1);
        rd(1, 6'd63, 0, 6'd0, 0);
        rd(0, 6'd0, 0, 6'd0, -1);

        do_load(2, 1'b1, 1'b1);
        rd(1, 6'd3, 1, 6'd32, 1);
        rd(1, 6'd3, 0, 6'd0, 0);
        rd(0, 6'd0, 1, 6'd0, 1);

        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sk_valid = 1'b1;
            sk_data  = mkw(3, k);
            words[k] = sk_data;
            wq.push_back('{6'(k), sk_data});
            @(posedge clk); #1;
        end
        sk_data = mkw(3, 10);
        rstn = 1'b0;
        #1 chk_reset_outputs();
        @(posedge clk); #1;
        rstn = 1'b1;
        sk_valid = 1'b0;
        for (int i = 0; i < 3; i++) rd(1, 6'd4, 1, 6'd4, -1);
        chk("keys_ready_after_abort", keys_ready, 0);

        do_load(4, 1'b0, 1'b0);
        rd(1, 6'd4, 0, 6'd0, 0);
        rd(0, 6'd0, 1, 6'd10, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rd_queue_empty", rq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
